// File: rtl/circular_slot_tracker.sv
// Circular slot buffer: in-order allocate at tail, out-of-order mark ready by
// index, in-order retire from head. Publishes the live window for the encoder.
module circular_slot_tracker #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  localparam int SLOTS     = 1 << ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  alloc_valid,
  input  logic [DATA_WIDTH-1:0] alloc_data,
  output logic                  alloc_ready,
  output logic [ADDR_WIDTH-1:0] alloc_index,
  input  logic                  mark_valid,
  input  logic [ADDR_WIDTH-1:0] mark_index,
  output logic                  commit_valid,
  output logic [DATA_WIDTH-1:0] commit_data,
  output logic [ADDR_WIDTH-1:0] commit_index,
  input  logic                  commit_ready,
  output logic [ADDR_WIDTH-1:0] head,
  output logic [ADDR_WIDTH-1:0] tail,
  output logic [SLOTS-1:0]      ready_vec,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);

  logic [ADDR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [SLOTS-1:0]      occ_q, occ_d, rdy_q, rdy_d;
  logic [DATA_WIDTH-1:0] data_q [SLOTS];
  logic                  alloc_fire, commit_fire;

  assign full         = (count_q == (ADDR_WIDTH+1)'(SLOTS));
  assign empty        = (count_q == '0);
  assign alloc_ready  = ~full;
  assign alloc_index  = tail_q;
  assign commit_valid = occ_q[head_q] & rdy_q[head_q];
  assign commit_data  = data_q[head_q];
  assign commit_index = head_q;
  assign head         = head_q;
  assign tail         = tail_q;
  assign count        = count_q;
  assign ready_vec    = occ_q & rdy_q;

  assign alloc_fire  = alloc_valid & alloc_ready;
  assign commit_fire = commit_valid & commit_ready;

  // Mark applies first so a same-index commit or alloc overrides it.
  always_comb begin
    occ_d   = occ_q;
    rdy_d   = rdy_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mark_valid && occ_q[mark_index]) rdy_d[mark_index] = 1'b1;
    if (commit_fire) begin
      occ_d[head_q] = 1'b0;
      rdy_d[head_q] = 1'b0;
      head_d        = head_q + 1'b1;
    end
    if (alloc_fire) begin
      occ_d[tail_q] = 1'b1;
      rdy_d[tail_q] = 1'b0;
      tail_d        = tail_q + 1'b1;
    end
    case ({alloc_fire, commit_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      occ_q   <= '0;
      rdy_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      occ_q   <= occ_d;
      rdy_q   <= rdy_d;
    end
  end

  // Payload storage needs no reset; occupancy gates every read.
  always_ff @(posedge clock) begin
    if (!reset && !flush && alloc_fire) data_q[tail_q] <= alloc_data;
  end

  logic [SLOTS-1:0] win_mask;
  always_comb begin
    win_mask = '0;
    for (int i = 0; i < SLOTS; i++) begin
      logic [ADDR_WIDTH-1:0] off;
      off         = ADDR_WIDTH'(i) - head_q;
      win_mask[i] = ({1'b0, off} < count_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert ($countones(occ_q) == int'(count_q));
      assert ((rdy_q & ~occ_q) == '0);
      assert (occ_q == win_mask);
    end
  end

endmodule

// File: tb/tb_circular_slot_tracker.sv
// Bench for circular_slot_tracker: directed plan plus random traffic checked
// every cycle against an ordered-queue model of the live window.
module tb_circular_slot_tracker;
  localparam int AW = 3;
  localparam int DW = 32;
  localparam int SLOTS = 1 << AW;

  logic            clock = 0;
  logic            reset, flush, alloc_valid, mark_valid, commit_ready;
  logic [DW-1:0]   alloc_data;
  logic [AW-1:0]   mark_index;
  logic            alloc_ready, commit_valid, full, empty;
  logic [AW-1:0]   alloc_index, commit_index, head, tail;
  logic [DW-1:0]   commit_data;
  logic [SLOTS-1:0] ready_vec;
  logic [AW:0]     count;

  circular_slot_tracker #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_data(alloc_data),
    .alloc_ready(alloc_ready), .alloc_index(alloc_index),
    .mark_valid(mark_valid), .mark_index(mark_index),
    .commit_valid(commit_valid), .commit_data(commit_data),
    .commit_index(commit_index), .commit_ready(commit_ready),
    .head(head), .tail(tail), .ready_vec(ready_vec), .count(count),
    .full(full), .empty(empty));

  always #5 clock = ~clock;

  typedef struct { logic [DW-1:0] d; bit r; } ent_t;
  ent_t q[$];
  int   m_head = 0;
  bit   chk_en = 0;
  int   nvec = 0, nerr = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model step from the inputs present at the clock edge.
  task automatic model_step();
    bit cf, af;
    ent_t e;
    if (reset || flush) begin
      q.delete();
      m_head = 0;
    end else begin
      cf = (q.size() > 0) && q[0].r && commit_ready;
      af = alloc_valid && (q.size() < SLOTS);
      if (mark_valid) begin
        int off;
        off = (int'(mark_index) - m_head + SLOTS) % SLOTS;
        if (off < q.size()) q[off].r = 1;
      end
      if (cf) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % SLOTS;
      end
      if (af) begin
        e.d = alloc_data;
        e.r = 0;
        q.push_back(e);
      end
    end
  endtask

  function automatic logic [SLOTS-1:0] m_rv();
    logic [SLOTS-1:0] v = '0;
    for (int k = 0; k < q.size(); k++)
      if (q[k].r) v[(m_head + k) % SLOTS] = 1'b1;
    return v;
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      bit cv;
      cv = (q.size() > 0) && q[0].r;
      chk("head", head, m_head);
      chk("tail", tail, (m_head + q.size()) % SLOTS);
      chk("alloc_index", alloc_index, (m_head + q.size()) % SLOTS);
      chk("count", count, q.size());
      chk("full", full, q.size() == SLOTS);
      chk("empty", empty, q.size() == 0);
      chk("alloc_ready", alloc_ready, q.size() != SLOTS);
      chk("ready_vec", ready_vec, m_rv());
      chk("commit_valid", commit_valid, cv);
      chk("commit_index", commit_index, m_head);
      if (cv) chk("commit_data", commit_data, q[0].d);
    end
  end

  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic idle();
    reset = 0; flush = 0; alloc_valid = 0; mark_valid = 0; commit_ready = 0;
  endtask

  task automatic do_alloc(input logic [DW-1:0] d);
    idle(); alloc_valid = 1; alloc_data = d; cyc(); idle();
  endtask

  task automatic do_mark(input int idx);
    idle(); mark_valid = 1; mark_index = AW'(idx); cyc(); idle();
  endtask

  task automatic chk_cleared(string tag);
    chk({tag, "_head"}, head, 0);
    chk({tag, "_tail"}, tail, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_rv"}, ready_vec, 0);
    chk({tag, "_empty"}, empty, 1);
    chk({tag, "_cv"}, commit_valid, 0);
  endtask

  initial begin
    idle(); alloc_data = '0; mark_index = '0;
    reset = 1; cyc(); cyc(); reset = 0;
    chk_en = 1;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_cv", commit_valid, 0);
    chk("rst_rv", ready_vec, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);

    for (int i = 0; i < 3; i++) begin
      chk("pre_alloc_index", alloc_index, i);
      do_alloc(32'hA0 + i);
    end
    chk("a3_tail", tail, 3);
    chk("a3_count", count, 3);
    chk("a3_rv", ready_vec, 8'b0);
    chk("a3_cv", commit_valid, 0);

    do_mark(2);
    chk("m2_cv", commit_valid, 0);
    do_mark(0);
    chk("m20_rv", ready_vec, 8'b00000101);
    chk("m20_cv", commit_valid, 1);
    chk("m20_cd", commit_data, 32'hA0);
    commit_ready = 1; cyc(); idle();
    chk("c0_head", head, 1);
    chk("c0_cv", commit_valid, 0);

    for (int i = 0; i < 6; i++) do_alloc(32'hB0 + i);
    chk("fill_full", full, 1);
    chk("fill_aready", alloc_ready, 0);
    chk("fill_count", count, 8);
    do_alloc(32'hDEAD);
    chk("drop_count", count, 8);
    chk("drop_tail", tail, 1);
    do_mark(1);
    alloc_valid = 1; alloc_data = 32'hBEEF; commit_ready = 1; cyc(); idle();
    chk("fc_count", count, 7);
    chk("fc_tail", tail, 1);
    chk("fc_head", head, 2);

    flush = 1; cyc(); idle();
    for (int i = 0; i < 6; i++) do_alloc(32'hC0 + i);
    for (int i = 0; i < 6; i++) do_mark(i);
    commit_ready = 1;
    for (int i = 0; i < 6; i++) cyc();
    idle();
    chk("w_head", head, 6);
    chk("w_tail", tail, 6);
    chk("w_empty", empty, 1);
    for (int i = 0; i < 4; i++) do_alloc(32'hE0 + i);
    chk("w_tail2", tail, 2);
    do_mark(7); do_mark(0); do_mark(1);
    chk("w_rv", ready_vec, 8'b10000011);
    chk("w_cv", commit_valid, 0);

    do_mark(5);
    chk("unocc_rv", ready_vec, 8'b10000011);
    do_alloc(32'hF2);
    alloc_valid = 1; alloc_data = 32'hF3; mark_valid = 1; mark_index = 3; cyc(); idle();
    chk("am_rv", ready_vec, 8'b10000011);
    chk("am_count", count, 6);

    do_mark(6);
    commit_ready = 1; cyc(); idle();
    chk("pf_count", count, 5);
    alloc_valid = 1; alloc_data = 32'h11; mark_valid = 1; mark_index = 4;
    commit_ready = 1;
    chk("pf_cv", commit_valid, 1);
    flush = 1; cyc(); idle();
    chk_cleared("flush");

    for (int i = 0; i < 3; i++) do_alloc(32'h50 + i);
    do_mark(0);
    alloc_valid = 1; mark_valid = 1; mark_index = 1; commit_ready = 1;
    reset = 1; cyc(); idle();
    chk_cleared("midrst");

    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 299) == 0);
      flush        = ($urandom_range(0, 149) == 0);
      alloc_valid  = ($urandom_range(0, 9) < 6);
      alloc_data   = $urandom;
      mark_valid   = ($urandom_range(0, 9) < 7);
      mark_index   = AW'($urandom_range(0, SLOTS - 1));
      commit_ready = ($urandom_range(0, 9) < 6);
      cyc();
    end
    idle(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
